// File: rtl/cpu_clock_pkg.sv
// cpu_clock_pkg: state encoding shared by the PHI2 clock generator.
package cpu_clock_pkg;
  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
endpackage

// File: rtl/cpu_clock.sv
// cpu_clock: 6502 PHI2/RESB generator with run gating, single step and edge strobes.
module cpu_clock
  import cpu_clock_pkg::*;
#(
  parameter int HALF_PERIOD  = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  output logic        phi2,
  output logic        resb_n,
  output logic        phi2_rise,
  output logic        phi2_fall,
  output logic        running,
  output logic [31:0] cycles
);
  localparam int HW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HALF_TC = HW'(HALF_PERIOD - 1);
  localparam logic [RW-1:0] HOLD_TC = RW'(RESET_CYCLES);

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [RW-1:0] hold_q, hold_d;
  logic [31:0]   cycles_q, cycles_d;
  logic          phi2_q, phi2_d, rise_q, rise_d, fall_q, fall_d;
  logic          done_q, done_d, running_q, running_d, tc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_HALT;
      half_q    <= '0;
      hold_q    <= '0;
      cycles_q  <= '0;
      phi2_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      hold_q    <= hold_d;
      cycles_q  <= cycles_d;
      phi2_q    <= phi2_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    hold_d   = hold_q;
    cycles_d = cycles_q;
    phi2_d   = phi2_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    done_d   = done_q;
    tc       = half_q == HALF_TC;
    if (state_q == ST_HALT) begin
      half_d  = '0;
      phi2_d  = 1'b0;
      state_d = run ? ST_RUN : step ? ST_STEP : ST_HALT;
    end else if (state_q == ST_RUN && !run && !phi2_q) begin
      state_d = ST_HALT;
      half_d  = '0;
    end else begin
      // A high half always completes; the park/continue decision is made on the falling edge.
      half_d = tc ? '0 : half_q + 1'b1;
      if (tc) begin
        phi2_d = !phi2_q;
        rise_d = !phi2_q;
        fall_d = phi2_q;
      end
      if (fall_d) state_d = run ? ST_RUN : ST_HALT;
    end
    if (fall_d) begin
      cycles_d = cycles_q + 1'b1;
      if (!done_q) begin
        hold_d = hold_q + 1'b1;
        done_d = hold_d == HOLD_TC;
      end
    end
    running_d = state_d != ST_HALT;
  end

  assign phi2      = phi2_q;
  assign resb_n    = done_q;
  assign phi2_rise = rise_q;
  assign phi2_fall = fall_q;
  assign running   = running_q;
  assign cycles    = cycles_q;
endmodule

// File: tb/tb_cpu_clock.sv
// tb_cpu_clock: vector tables through a scoreboard queue, plus reset and wrap sequences.
module tb_cpu_clock;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0;
  logic phi2, resb_n, phi2_rise, phi2_fall, running;
  logic [31:0] cycles;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic run, step, phi2, resb, rise, fall, running;
    logic [31:0] cyc;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  cpu_clock #(.HALF_PERIOD(4), .RESET_CYCLES(2)) dut (
    .clock(clk), .reset(reset), .run(run), .step(step),
    .phi2(phi2), .resb_n(resb_n), .phi2_rise(phi2_rise), .phi2_fall(phi2_fall),
    .running(running), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(int n, logic r, logic s, logic p, logic rb, logic ri, logic fa, logic rn, logic [31:0] c);
    vec_t v;
    v = '{run: r, step: s, phi2: p, resb: rb, rise: ri, fall: fa, running: rn, cyc: c};
    repeat (n) tbl.push_back(v);
  endtask

  task automatic play(string tag);
    vec_t v, e;
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      sb.push_back(v);
      run  = v.run;
      step = v.step;
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("%s[%0d] phi2", tag, i), {31'd0, phi2}, {31'd0, e.phi2});
      chk($sformatf("%s[%0d] resb_n", tag, i), {31'd0, resb_n}, {31'd0, e.resb});
      chk($sformatf("%s[%0d] rise", tag, i), {31'd0, phi2_rise}, {31'd0, e.rise});
      chk($sformatf("%s[%0d] fall", tag, i), {31'd0, phi2_fall}, {31'd0, e.fall});
      chk($sformatf("%s[%0d] running", tag, i), {31'd0, running}, {31'd0, e.running});
      chk($sformatf("%s[%0d] cycles", tag, i), cycles, e.cyc);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    @(negedge clk);
    chk("reset phi2", {31'd0, phi2}, 32'd0);
    chk("reset resb_n", {31'd0, resb_n}, 32'd0);
    chk("reset strobes", {30'd0, phi2_rise, phi2_fall}, 32'd0);
    chk("reset running", {31'd0, running}, 32'd0);
    chk("reset cycles", cycles, 32'd0);
    reset = 1'b0;
  endtask

  task automatic startup_rows();
    add(4, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 1, 0, 1, 0);
    add(3, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1, 1);
    add(3, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(3, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 1, 2);
  endtask

  initial begin
    bit seen;
    @(negedge clk);
    do_reset();
    startup_rows();
    play("startup");

    do_reset();
    add(4, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 1, 0, 1, 0);
    add(3, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0, 0, 1);
    play("stop_high");

    do_reset();
    add(4, 1, 0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 0, 1, 0, 1, 0, 1, 0);
    add(3, 1, 0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 0, 1, 1, 1);
    add(4, 0, 0, 0, 0, 0, 0, 0, 1);
    add(4, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(3, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 1, 2);
    play("stop_low");

    do_reset();
    add(1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 1, 0, 1, 0);
    add(3, 0, 0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0, 1, 0, 1, 1);
    add(3, 1, 0, 1, 0, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 0, 1, 1, 2);
    add(1, 0, 0, 0, 1, 0, 0, 0, 2);
    add(1, 0, 1, 0, 1, 0, 0, 1, 2);
    add(3, 0, 0, 0, 1, 0, 0, 1, 2);
    add(1, 0, 0, 1, 1, 1, 0, 1, 2);
    add(2, 0, 0, 1, 1, 0, 0, 1, 2);
    add(1, 1, 0, 1, 1, 0, 0, 1, 2);
    add(1, 1, 0, 0, 1, 0, 1, 1, 3);
    add(3, 1, 0, 0, 1, 0, 0, 1, 3);
    add(1, 1, 0, 1, 1, 1, 0, 1, 3);
    play("step");

    do_reset();
    startup_rows();
    add(3, 1, 0, 0, 1, 0, 0, 1, 2);
    add(1, 1, 0, 1, 1, 1, 0, 1, 2);
    add(2, 1, 0, 1, 1, 0, 0, 1, 2);
    play("pre_reset");
    #2 reset = 1'b1;
    #1;
    chk("midreset phi2", {31'd0, phi2}, 32'd0);
    chk("midreset resb_n", {31'd0, resb_n}, 32'd0);
    chk("midreset cycles", cycles, 32'd0);
    chk("midreset running", {31'd0, running}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    startup_rows();
    play("restart");

    force dut.cycles_q = 32'hFFFF_FFFF;
    #1 release dut.cycles_q;
    chk("wrap preload", cycles, 32'hFFFF_FFFF);
    run  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = phi2_fall;
    end
    chk("wrap fall seen", {31'd0, seen}, 32'd1);
    chk("wrap cycles", cycles, 32'd0);
    chk("wrap resb_n", {31'd0, resb_n}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
